// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder, LSB first, one bit per clock through a single full-adder cell.
// Define SERIAL_ADDER_CARRY_EN to add the registered Carry_o output.

module serial_adder_ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  logic s1, c1, c2;

  serial_adder_ha u_ha0 (.a_i(a_i), .b_i(b_i),   .s_o(s1),  .c_o(c1));
  serial_adder_ha u_ha1 (.a_i(s1),  .b_i(cin_i), .s_o(s_o), .c_o(c2));

  assign cout_o = c1 | c2;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] In1_i,
  input  logic [WIDTH-1:0] In2_i,
  output logic             busy_o,
  output logic             done_o,
`ifdef SERIAL_ADDER_CARRY_EN
  output logic             Carry_o,
`endif
  output logic [WIDTH-1:0] Sum_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sumBit, carryNext;
`ifdef SERIAL_ADDER_CARRY_EN
  logic             carryOut_q, carryOut_d;
`endif

  serial_adder_fa u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .s_o   (sumBit),
    .cout_o(carryNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
`ifdef SERIAL_ADDER_CARRY_EN
      carryOut_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
`ifdef SERIAL_ADDER_CARRY_EN
      carryOut_q <= carryOut_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
`ifdef SERIAL_ADDER_CARRY_EN
    carryOut_d = carryOut_q;
`endif
    busy_o     = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = In1_i;
          b_d     = In2_i;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        busy_o  = 1'b1;
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
        sum_d   = {sumBit, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carryNext;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
`ifdef SERIAL_ADDER_CARRY_EN
          carryOut_d = carryNext;
`endif
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Sum_o = sum_q;
`ifdef SERIAL_ADDER_CARRY_EN
  assign Carry_o = carryOut_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); Carry_o is checked only
// when SERIAL_ADDER_CARRY_EN is defined.

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] In1_i = '0;
  logic [WIDTH-1:0] In2_i = '0;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] Sum_o;
`ifdef SERIAL_ADDER_CARRY_EN
  logic             Carry_o;
`endif

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    int               doneCyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .In1_i  (In1_i),
    .In2_i  (In2_i),
    .busy_o (busy_o),
    .done_o (done_o),
`ifdef SERIAL_ADDER_CARRY_EN
    .Carry_o(Carry_o),
`endif
    .Sum_o  (Sum_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon = sb.pop_front();
        checkOutput("sum", 32'(Sum_o), 32'(mon.sum));
`ifdef SERIAL_ADDER_CARRY_EN
        checkOutput("carry", 32'(Carry_o), 32'(mon.carry));
`endif
        checkOutput("done_latency", cyc, mon.doneCyc);
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) checkOutput("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) checkOutput("drain_timeout", sb.size(), 32'd0);
  endtask

  // Drives start at a negedge while idle; the next rising edge accepts it.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] expSum, input logic expCarry,
                               input bit keep, output int accCyc);
    exp_t e;
    waitIdle();
    In1_i   = a;
    In2_i   = b;
    start_i = 1'b1;
    e.sum     = expSum;
    e.carry   = expCarry;
    e.doneCyc = cyc + 1 + WIDTH;
    sb.push_back(e);
    accCyc = cyc + 1;
    @(negedge clk);
    if (!keep) start_i = 1'b0;
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } vec_t;

  vec_t b2b[4] = '{
    '{8'h80, 8'h80, 8'h00, 1'b1},
    '{8'h7F, 8'h01, 8'h80, 1'b0},
    '{8'hC8, 8'h64, 8'h2C, 1'b1},
    '{8'h12, 8'h34, 8'h46, 1'b0}
  };

  initial begin
    int acc, prevAcc;

    #12;
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_sum",  32'(Sum_o),  32'd0);

    // Start driven on the same negedge reset releases: the first edge takes it.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, acc);
    applyStimulus(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, acc);
    waitDrain();
    repeat (4) @(negedge clk);
    checkOutput("hold_sum",  32'(Sum_o),  32'h0FF);
    checkOutput("hold_busy", 32'(busy_o), 32'd0);

    // Starts during ADD/DONE must be ignored.
    applyStimulus(8'h3C, 8'hC3, 8'hFF, 1'b0, 1'b0, acc);
    checkOutput("busy_in_add", 32'(busy_o), 32'd1);
    repeat (2) @(negedge clk);
    start_i = 1'b1; In1_i = 8'hFF; In2_i = 8'hFF;
    @(negedge clk);
    start_i = 1'b0; In1_i = 8'h11; In2_i = 8'h22;
    repeat (4) @(negedge clk);
    start_i = 1'b1; In1_i = 8'h80; In2_i = 8'h80;
    @(negedge clk);
    start_i = 1'b0;
    waitDrain();
    repeat (12) @(negedge clk);
    checkOutput("ignored_sum",  32'(Sum_o),  32'h0FF);
    checkOutput("ignored_busy", 32'(busy_o), 32'd0);

    // Reset on add cycle 4 aborts the operation immediately.
    applyStimulus(8'h12, 8'h34, 8'h46, 1'b0, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("abort_sum",  32'(Sum_o),  32'd0);
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_done", 32'(done_o), 32'd0);
`ifdef SERIAL_ADDER_CARRY_EN
    checkOutput("abort_carry", 32'(Carry_o), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, acc);
    waitDrain();

    // Start held high: one acceptance every WIDTH+2 cycles.
    prevAcc = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(b2b[k].a, b2b[k].b, b2b[k].s, b2b[k].c, 1'b1, acc);
      if (k > 0) checkOutput("b2b_period", acc - prevAcc, WIDTH + 2);
      prevAcc = acc;
    end
    start_i = 1'b0;
    waitDrain();
    repeat (3) @(negedge clk);

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to add In1 and In2; sampled only in IDLE.
REQ-005 In1  input  WIDTH  first operand; captured on accepted start.
REQ-006 In2  input  WIDTH  second operand; captured on accepted start.
REQ-007 busy  output  1  high while in ADD or DONE; requester must not expect start to be taken.
REQ-008 done  output  1  single-cycle pulse; Sum (and Carry) are valid from this cycle.
REQ-009 Sum  output  WIDTH  registered result.
REQ-010 Carry  output  1  registered carry-out of the MSB; present only with SERIAL_ADDER_CARRY_EN.

Function
REQ-011 The block SHALL compute In1+In2 bit-serially, LSB first, one bit per clock, using a single one-bit full-adder cell built from two half-adder stages and an OR of their carries.
REQ-012 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-013 IDLE: start=1 SHALL capture In1/In2 into shift registers, clear the carry register and the bit counter, and enter ADD; start=0 stays in IDLE.
REQ-014 ADD: each cycle SHALL add operand bit 0 plus the carry register, shift the sum bit into the MSB of the Sum shift register, shift both operands right, update the carry register, and increment the counter.
REQ-015 ADD SHALL exit to DONE after exactly WIDTH add cycles (counter reaches WIDTH-1 in the final add cycle).
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-017 Latency: start accepted on edge N -> done high during the cycle after edge N+WIDTH (WIDTH+1 cycles, start to done).
REQ-018 start while busy=1 (ADD or DONE) SHALL be ignored with no effect on state, operands, or result.
REQ-019 Sum and Carry SHALL hold their last result unchanged in IDLE until the next accepted start; intermediate shift values are visible on Sum during ADD and are not valid.
REQ-020 Result arithmetic SHALL be modulo 2^WIDTH on Sum; the overflow bit goes only to Carry.
REQ-021 In1/In2 changes after an accepted start SHALL NOT affect the current result.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, Sum=0, Carry=0, counter=0, carry register=0, operand registers=0.
REQ-023 Reset asserted mid-ADD SHALL abort the operation; no done pulse is produced for it.
REQ-024 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-025 Macro SERIAL_ADDER_CARRY_EN defined: Carry port exists and is loaded from the carry register in the DONE transition.
REQ-026 Macro undefined: no Carry port and no Carry output register; Sum behaviour and latency are identical.

Verification
REQ-027 WIDTH=8, In1=0x00, In2=0x00, start pulse -> done 9 cycles later, Sum=0x00, Carry=0.
REQ-028 In1=0xFF, In2=0x01 -> Sum=0x00, Carry=1; In1=0xA5, In2=0x5A -> Sum=0xFF, Carry=0.
REQ-029 start re-pulsed with new operands on cycles 3 and 8 of a running add -> ignored; result and done timing match the first request only.
REQ-030 rst_n pulled low on add cycle 4 -> outputs immediately 0, no done; a new start after release yields a correct result.
REQ-031 Back-to-back: start held high continuously -> one accepted start per 10 cycles (WIDTH+2), each done paired with correct Sum.
REQ-032 Build without SERIAL_ADDER_CARRY_EN: 0xFF+0x01 -> Sum=0x00, same latency, no Carry port.
